// File: rtl/uart_tx_pkg.sv
// Shared constants and state type for the UART transmit frame sequencer.
package uart_tx_pkg;
  localparam int         FRAME_BITS   = 10;
  localparam logic [3:0] LAST_BIT_IDX = 4'd9;
  localparam logic       START_BIT    = 1'b0;
  localparam logic       STOP_BIT     = 1'b1;

  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/uart_bit_timer.sv
// Loadable bit-period down-counter. A load takes max(period, MIN_PERIOD) - 1,
// and expire is high while the count sits at zero.
module uart_bit_timer #(
  parameter int WIDTH      = 8,
  parameter int MIN_PERIOD = 2
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] period,
  output logic             expire
);
  localparam logic [WIDTH-1:0] MIN_P = WIDTH'(MIN_PERIOD);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] eff_period;

  assign eff_period = (period < MIN_P) ? MIN_P : period;
  assign expire     = (cnt == '0);

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N)               cnt <= '0;
    else if (load)              cnt <= eff_period - ONE;
    else if (en && cnt != '0)   cnt <= cnt - ONE;
  end
endmodule

// File: rtl/uart_tx_frame_sequencer.sv
// UART transmit sequencer: frames bytes (start, 8 data LSB first, stop), walks
// the baud-period ROM one bit ahead so bits run back to back.
// Optional UART_TX_FRAME_CNT_EN adds a 16-bit completed-frame counter.
module uart_tx_frame_sequencer
  import uart_tx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MIN_PERIOD = 2
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [3:0]       rom_addr,
  input  logic [WIDTH-1:0] rom_data,
  output logic             tx_out,
  output logic             busy,
  output logic             frame_done
`ifdef UART_TX_FRAME_CNT_EN
  ,output logic [15:0]     frame_cnt
`endif
);
  state_t     state, state_nxt;
  logic [8:0] shift;   // remaining bits after the one on the line: data then stop
  logic [3:0] bit_idx;
  logic       accept, expire, advance, last_done, load;

  assign tx_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = tx_valid && tx_ready;
  assign advance   = (state == SEND) && expire && (bit_idx != LAST_BIT_IDX);
  assign last_done = (state == SEND) && expire && (bit_idx == LAST_BIT_IDX);
  assign load      = accept || advance;

  // Prefetch the next bit's period; P0 is pre-addressed during the stop bit
  // and in IDLE so a new frame can start without waiting on the ROM.
  assign rom_addr = (state == SEND && bit_idx != LAST_BIT_IDX) ? bit_idx + 4'd1 : 4'd0;

  uart_bit_timer #(.WIDTH(WIDTH), .MIN_PERIOD(MIN_PERIOD)) u_timer (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .load    (load),
    .en      (state == SEND),
    .period  (rom_data),
    .expire  (expire)
  );

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = SEND;
      SEND:    if (last_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      shift      <= '0;
      bit_idx    <= '0;
      tx_out     <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last_done;
      if (accept) begin
        shift   <= {STOP_BIT, tx_data};
        bit_idx <= '0;
        tx_out  <= START_BIT;
      end else if (advance) begin
        shift   <= shift >> 1;
        bit_idx <= bit_idx + 4'd1;
        tx_out  <= shift[0];
      end else if (last_done) begin
        tx_out  <= 1'b1;
      end
    end
  end

`ifdef UART_TX_FRAME_CNT_EN
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N)       frame_cnt <= '0;
    else if (last_done) frame_cnt <= frame_cnt + 16'd1;
  end
`endif
endmodule
